// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 line-fill port between the instruction
// and data caches. It arbitrates round-robin on conflict, issues one
// line-aligned read at a time, returns the line to the winner and keeps
// saturating grant/conflict statistics.
module l2_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 512,
    parameter int OFFSET_W = 6
) (
    input  logic              clk,
    input  logic              clear,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_add,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_data,

    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_add,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_data,

    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_add,
    input  logic              l2_ack,
    input  logic [LINE_W-1:0] l2_data,

    output logic              busy,
    output logic [31:0]       i_grants,
    output logic [31:0]       d_grants,
    output logic [31:0]       conflicts
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requester identity used for owner / last_owner.
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Keeps the upper address bits, clears the line offset.
    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              l2_req_q, l2_req_d;
    logic [ADDR_W-1:0] l2_add_q, l2_add_d;
    logic [LINE_W-1:0] i_data_q, i_data_d;
    logic [LINE_W-1:0] d_data_q, d_data_d;
    logic              busy_q, busy_d;
    logic [31:0]       i_grants_q, i_grants_d;
    logic [31:0]       d_grants_q, d_grants_d;
    logic [31:0]       conflicts_q, conflicts_d;

    logic              grant_sel;
    logic [ADDR_W-1:0] grant_add;

    // Statistics stop at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        l2_req_d     = l2_req_q;
        l2_add_d     = l2_add_q;
        i_data_d     = i_data_q;
        d_data_d     = d_data_q;
        i_grants_d   = i_grants_q;
        d_grants_d   = d_grants_q;
        conflicts_d  = conflicts_q;
        grant_sel    = OWNER_I;
        grant_add    = i_add;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On conflict the requester that was not served last wins.
                    if (i_req && d_req) begin
                        grant_sel   = ~last_owner_q;
                        conflicts_d = sat_inc(conflicts_q);
                    end else begin
                        grant_sel = d_req ? OWNER_D : OWNER_I;
                    end
                    grant_add    = (grant_sel == OWNER_D) ? d_add : i_add;
                    owner_d      = grant_sel;
                    last_owner_d = grant_sel;
                    l2_req_d     = 1'b1;
                    l2_add_d     = grant_add & LINE_MASK;
                    if (grant_sel == OWNER_D) begin
                        d_grants_d = sat_inc(d_grants_q);
                    end else begin
                        i_grants_d = sat_inc(i_grants_q);
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Requester inputs are ignored while the fill is in flight.
                if (l2_ack) begin
                    l2_req_d = 1'b0;
                    if (owner_q == OWNER_D) begin
                        d_data_d = l2_data;
                        d_ack_d  = 1'b1;
                    end else begin
                        i_data_d = l2_data;
                        i_ack_d  = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // The ack pulse lives only in this state; return to IDLE next.
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                l2_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; clear abandons any transaction in flight.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_I;
            // Data was served last, so the instruction side wins the first conflict.
            last_owner_q <= OWNER_D;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            l2_req_q     <= 1'b0;
            l2_add_q     <= '0;
            // NOTE: the wide line registers are reset because the returned data buses must read zero after clear.
            i_data_q     <= '0;
            d_data_q     <= '0;
            busy_q       <= 1'b0;
            i_grants_q   <= '0;
            d_grants_q   <= '0;
            conflicts_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            l2_req_q     <= l2_req_d;
            l2_add_q     <= l2_add_d;
            i_data_q     <= i_data_d;
            d_data_q     <= d_data_d;
            busy_q       <= busy_d;
            i_grants_q   <= i_grants_d;
            d_grants_q   <= d_grants_d;
            conflicts_q  <= conflicts_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_data    = i_data_q;
    assign d_data    = d_data_q;
    assign l2_req    = l2_req_q;
    assign l2_add    = l2_add_q;
    assign busy      = busy_q;
    assign i_grants  = i_grants_q;
    assign d_grants  = d_grants_q;
    assign conflicts = conflicts_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Testbench for l2_port_arbiter: directed scenarios plus a randomized phase,
// all checked every cycle against a transaction-level model of the port.
module tb_l2_port_arbiter;

    localparam int AW = 32;
    localparam int LW = 512;

    logic          clk = 1'b0;
    logic          clear;
    logic          i_req, d_req;
    logic [AW-1:0] i_add, d_add;
    logic          i_ack, d_ack;
    logic [LW-1:0] i_data, d_data;
    logic          l2_req;
    logic [AW-1:0] l2_add;
    logic          l2_ack;
    logic [LW-1:0] l2_data;
    logic          busy;
    logic [31:0]   i_grants, d_grants, conflicts;

    int n_cmp = 0;
    int n_bad = 0;

    // L2 responder controls.
    int            fixed_delay   = -1;
    bit            fixed_data_en = 1'b0;
    logic [LW-1:0] fixed_data    = '0;
    bit            stray_always  = 1'b0;
    bit            stray_rand    = 1'b0;
    bit            inject_ack    = 1'b0;

    always #5 clk = ~clk;

    l2_port_arbiter dut (
        .clk       (clk),
        .clear     (clear),
        .i_req     (i_req),
        .i_add     (i_add),
        .i_ack     (i_ack),
        .i_data    (i_data),
        .d_req     (d_req),
        .d_add     (d_add),
        .d_ack     (d_ack),
        .d_data    (d_data),
        .l2_req    (l2_req),
        .l2_add    (l2_add),
        .l2_ack    (l2_ack),
        .l2_data   (l2_data),
        .busy      (busy),
        .i_grants  (i_grants),
        .d_grants  (d_grants),
        .conflicts (conflicts)
    );

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- transaction-level reference model ----------------
    // Requester index: 0 = instruction, 1 = data.
    int            m_owner;      // requester whose fill is outstanding at L2, -1 if none
    bit            m_done;       // a line is being handed back this cycle
    int            m_done_who;
    int            m_last;       // requester served most recently
    logic [31:0]   m_cnt [3];    // i grants, d grants, conflicts
    logic [LW-1:0] m_line [2];
    logic [AW-1:0] m_l2_add;

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task model_reset();
        m_owner    = -1;
        m_done     = 1'b0;
        m_done_who = 0;
        m_last     = 1;
        for (int k = 0; k < 3; k++) m_cnt[k] = '0;
        m_line[0]  = '0;
        m_line[1]  = '0;
        m_l2_add   = '0;
    endtask

    // Advance the model across the coming clock edge using the inputs now present.
    task model_step();
        int  w;
        bit  both;
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_owner >= 0) begin
            if (l2_ack) begin
                m_line[m_owner] = l2_data;
                m_done          = 1'b1;
                m_done_who      = m_owner;
                m_owner         = -1;
            end
        end else if (i_req || d_req) begin
            both = i_req && d_req;
            w    = both ? 1 - m_last : (i_req ? 0 : 1);
            if (both) m_cnt[2] = sat(m_cnt[2]);
            m_cnt[w] = sat(m_cnt[w]);
            m_last   = w;
            m_owner  = w;
            m_l2_add = ((w == 0) ? i_add : d_add) & ~32'h3F;
        end
    endtask

    initial begin : compare
        model_reset();
        forever begin
            @(negedge clk);
            if (clear) model_reset();
            check("i_ack",     i_ack,     m_done && m_done_who == 0);
            check("d_ack",     d_ack,     m_done && m_done_who == 1);
            check("l2_req",    l2_req,    m_owner >= 0);
            check("busy",      busy,      (m_owner >= 0) || m_done);
            if (m_owner >= 0) check("l2_add", l2_add, m_l2_add);
            check("i_data",    i_data,    m_line[0]);
            check("d_data",    d_data,    m_line[1]);
            check("i_grants",  i_grants,  m_cnt[0]);
            check("d_grants",  d_grants,  m_cnt[1]);
            check("conflicts", conflicts, m_cnt[2]);
            if (!clear) model_step();
        end
    end

    // ---------------- L2 responder ----------------
    initial begin : l2_responder
        int cnt;
        int target;
        l2_ack  = 1'b0;
        l2_data = '0;
        cnt     = 0;
        target  = 0;
        forever begin
            @(posedge clk);
            #1;
            l2_ack = 1'b0;
            if (inject_ack) begin
                inject_ack = 1'b0;
                l2_ack     = 1'b1;
                l2_data    = rand_line();
            end else if (clear) begin
                cnt = 0;
            end else if (l2_req) begin
                if (cnt == 0) target = (fixed_delay >= 0) ? fixed_delay : $urandom_range(4);
                if (cnt >= target) begin
                    l2_ack  = 1'b1;
                    l2_data = fixed_data_en ? fixed_data : rand_line();
                    cnt     = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                if (stray_always || (stray_rand && $urandom_range(7) == 0)) begin
                    l2_ack  = 1'b1;
                    l2_data = rand_line();
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(posedge clk);
        #1;
        clear = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Wait for the ack of requester 'who'; report the first l2_add seen with l2_req.
    task automatic wait_ack(input int who, input int bound,
                            output logic [AW-1:0] seen_add, output bit other_ack);
        bit got;
        bit seen;
        got       = 1'b0;
        seen      = 1'b0;
        seen_add  = '0;
        other_ack = 1'b0;
        for (int c = 0; c < bound && !got; c++) begin
            @(posedge clk);
            #1;
            if (l2_req && !seen) begin
                seen     = 1'b1;
                seen_add = l2_add;
            end
            if ((who == 0) ? d_ack : i_ack) other_ack = 1'b1;
            if ((who == 0) ? i_ack : d_ack) got = 1'b1;
        end
        check("ack_arrived", got, 1'b1);
    endtask

    task automatic fill(input int who, input logic [AW-1:0] add);
        logic [AW-1:0] s;
        bit            o;
        @(posedge clk);
        #1;
        if (who == 0) begin i_req = 1'b1; i_add = add; end
        else          begin d_req = 1'b1; d_add = add; end
        wait_ack(who, 40, s, o);
        if (who == 0) i_req = 1'b0; else d_req = 1'b0;
    endtask

    // ---------------- main stimulus ----------------
    initial begin : stim
        logic [AW-1:0] seen;
        bit            oth;
        int            who;
        int            cyc;

        clear = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        i_add = '0;
        d_add = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     busy,     1'b0);
        check("rst_l2_req",   l2_req,   1'b0);
        check("rst_i_grants", i_grants, 32'd0);
        check("rst_i_data",   i_data,   '0);
        clear = 1'b0;

        // Single instruction fill, L2 answers after a delay with a fixed pattern.
        fixed_delay   = 4;
        fixed_data_en = 1'b1;
        fixed_data    = {64{8'hA5}};
        @(posedge clk);
        #1;
        i_req = 1'b1;
        i_add = 32'h0000_1234;
        wait_ack(0, 30, seen, oth);
        i_req = 1'b0;
        check("t1_l2_add",   seen,     32'h0000_1200);
        check("t1_no_d_ack", oth,      1'b0);
        check("t1_i_data",   i_data,   {64{8'hA5}});
        check("t1_i_grants", i_grants, 32'd1);
        @(posedge clk);
        #1;
        check("t1_ack_pulse", i_ack, 1'b0);
        fixed_data_en = 1'b0;

        // Simultaneous requests straight after reset: instruction first.
        do_reset();
        i_req = 1'b1;
        i_add = 32'h0000_0040;
        d_req = 1'b1;
        d_add = 32'h0000_0080;
        wait_ack(0, 30, seen, oth);
        i_req = 1'b0;
        check("t2_first_add", seen, 32'h0000_0040);
        wait_ack(1, 30, seen, oth);
        d_req = 1'b0;
        check("t2_second_add", seen,      32'h0000_0080);
        check("t2_conflicts",  conflicts, 32'd1);
        check("t2_i_grants",   i_grants,  32'd1);
        check("t2_d_grants",   d_grants,  32'd1);

        // Round-robin fairness with both requests held.
        do_reset();
        fixed_delay = -1;
        i_req = 1'b1;
        i_add = $urandom;
        d_req = 1'b1;
        d_add = $urandom;
        for (int n = 0; n < 6; n++) begin
            who = -1;
            for (int c = 0; c < 40 && who < 0; c++) begin
                @(posedge clk);
                #1;
                if (i_ack) who = 0;
                else if (d_ack) who = 1;
            end
            check("rr_order", who, n % 2);
            if (who == 0) i_req = 1'b0;
            if (who == 1) d_req = 1'b0;
            if (n == 5 || who < 0) begin
                i_req = 1'b0;
                d_req = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            if (who == 0) begin i_req = 1'b1; i_add = $urandom; end
            else          begin d_req = 1'b1; d_add = $urandom; end
        end
        repeat (3) @(posedge clk);
        #1;
        check("rr_i_grants", i_grants, 32'd3);
        check("rr_d_grants", d_grants, 32'd3);

        // Stray l2_ack while idle.
        do_reset();
        stray_always = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("stray_i_ack", i_ack, 1'b0);
            check("stray_d_ack", d_ack, 1'b0);
            check("stray_busy",  busy,  1'b0);
        end
        stray_always = 1'b0;

        // clear in the middle of a fill, then a late ack from L2.
        fixed_delay = 3;
        @(posedge clk);
        #1;
        i_req = 1'b1;
        i_add = $urandom;
        cyc = 0;
        while (!l2_req && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("t5_l2_req_up", l2_req, 1'b1);
        #1;
        clear = 1'b1;
        i_req = 1'b0;
        #1;
        check("t5_async_l2_req", l2_req, 1'b0);
        check("t5_async_busy",   busy,   1'b0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        #1;
        inject_ack = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("t5_no_ack", i_ack, 1'b0);
        end
        check("t5_i_grants",  i_grants,  32'd0);
        check("t5_d_grants",  d_grants,  32'd0);
        check("t5_conflicts", conflicts, 32'd0);
        fill(0, $urandom);
        check("t5_refill_grants", i_grants, 32'd1);

        // Saturation of the instruction grant counter.
        do_reset();
        fixed_delay = 0;
        @(posedge clk);
        #2;
        force dut.i_grants_q = 32'hFFFF_FFFE;
        m_cnt[0] = 32'hFFFF_FFFE;
        @(posedge clk);
        #2;
        release dut.i_grants_q;
        repeat (3) fill(0, $urandom);
        check("sat_i_grants", i_grants, 32'hFFFF_FFFF);

        // Randomized traffic with random L2 latency and stray acks.
        do_reset();
        fixed_delay = -1;
        stray_rand  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (i_ack) i_req = 1'b0;
            else if (!i_req && $urandom_range(3) == 0) begin
                i_req = 1'b1;
                i_add = $urandom;
            end
            if (d_ack) d_req = 1'b0;
            else if (!d_req && $urandom_range(3) == 0) begin
                d_req = 1'b1;
                d_add = $urandom;
            end
        end
        // Let outstanding work drain.
        cyc = 0;
        while ((i_req || d_req) && cyc < 60) begin
            @(posedge clk);
            #1;
            if (i_ack) i_req = 1'b0;
            if (d_ack) d_req = 1'b0;
            cyc++;
        end
        check("drain_done", i_req || d_req, 1'b0);
        stray_rand = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "time limit");
    end

endmodule
